// File: rtl/sram_burst_seq.sv
// sram_burst_seq: turns byte-burst commands into single-byte accesses on an
// SRAM controller (start/busy/data_ready handshake), one beat at a time.
// Write bytes come in on wr_valid/wr_ready, read bytes go out on rd_valid/rd_ready.
// Optional build macro: SRAM_SEQ_ADDR_WRAP_EN -- when defined, a burst wraps
// from address 1023 to 0; when undefined, a burst that would run past 1023
// is accepted and then rejected with an err pulse, without touching the SRAM.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | cmd_ready high, waiting for a burst command
// FETCH     | write: wait for the next write byte; read: pass straight through
// ISSUE     | one-cycle start_operation pulse to the controller
// WAIT_BUSY | wait for busy to rise, give up after BUSY_TMO cycles
// WAIT_DONE | controller working; read data captured on data_ready_signal
// HOLD      | read byte presented on rd_valid until rd_ready
module sram_burst_seq #(
    parameter int BUSY_TMO = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [9:0] cmd_addr,
    input  logic [9:0] cmd_len,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       done,
    output logic       err,
    output logic       start_operation,
    output logic       rw,
    output logic [9:0] address_input,
    output logic [7:0] data_f2s,
    input  logic [7:0] data_s2f,
    input  logic       data_ready_signal,
    input  logic       busy_signal
);

    localparam int TW = (BUSY_TMO < 2) ? 1 : $clog2(BUSY_TMO);
    localparam logic [TW-1:0] TMO_LOAD = TW'(BUSY_TMO - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        HOLD      = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            rw_q, rw_d;
    logic [9:0]      addr_q, addr_d;
    logic [9:0]      cnt_q, cnt_d;
    logic [7:0]      wdat_q, wdat_d;
    logic [7:0]      rdat_q, rdat_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            ovf_q, ovf_d;
    logic            rdy_en_q;

    logic            ovf_cmd;
    logic            accept;
    logic            beat_end;
    logic            last_beat;
    logic            tmo_hit;

`ifdef SRAM_SEQ_ADDR_WRAP_EN
    // Address simply rolls over inside the 10-bit counter.
    assign ovf_cmd = 1'b0;
`else
    // Bursts that would run off the top of the array are refused up front.
    logic [10:0] end_addr;
    assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign ovf_cmd  = end_addr[10];
`endif

    // Shared decode of the handshake events the FSM reacts to.
    always_comb begin
        accept    = (state_q == IDLE) && rdy_en_q && cmd_valid;
        beat_end  = ((state_q == WAIT_DONE) && !busy_signal && !rw_q) ||
                    ((state_q == HOLD) && rd_ready);
        last_beat = (cnt_q == '0);
        tmo_hit   = (state_q == WAIT_BUSY) && !busy_signal && (tmr_q == '0);
    end

    // State register; rdy_en_q keeps cmd_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = FETCH;
            end
            FETCH: begin
                if (ovf_q)         state_d = IDLE;
                else if (rw_q)     state_d = ISSUE;
                else if (wr_valid) state_d = ISSUE;
            end
            ISSUE: begin
                // Never start on top of a controller that still reports busy.
                if (!busy_signal) state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_signal)  state_d = WAIT_DONE;
                else if (tmo_hit) state_d = IDLE;
            end
            WAIT_DONE: begin
                if (!busy_signal) begin
                    if (rw_q)           state_d = HOLD;
                    else if (last_beat) state_d = IDLE;
                    else                state_d = FETCH;
                end
            end
            HOLD: begin
                if (rd_ready) state_d = last_beat ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: command latch, byte registers, beat counter and busy timer.
    always_comb begin
        rw_d   = rw_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        wdat_d = wdat_q;
        rdat_d = rdat_q;
        tmr_d  = tmr_q;
        ovf_d  = ovf_q;
        if (accept) begin
            rw_d   = cmd_rw;
            addr_d = cmd_addr;
            cnt_d  = cmd_len;
            ovf_d  = ovf_cmd;
        end
        if ((state_q == FETCH) && !rw_q && !ovf_q && wr_valid) wdat_d = wr_data;
        if (state_q == ISSUE) tmr_d = TMO_LOAD;
        if ((state_q == WAIT_BUSY) && !busy_signal && (tmr_q != '0)) tmr_d = tmr_q - TW'(1);
        if ((state_q == WAIT_DONE) && rw_q && data_ready_signal) rdat_d = data_s2f;
        if (beat_end && !last_beat) begin
            cnt_d  = cnt_q - 10'd1;
            addr_d = addr_q + 10'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q   <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            wdat_q <= '0;
            rdat_q <= '0;
            tmr_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            rw_q   <= rw_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            wdat_q <= wdat_d;
            rdat_q <= rdat_d;
            tmr_q  <= tmr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Outputs decoded from state; done/err fire in the cycle the burst ends.
    always_comb begin
        cmd_ready       = (state_q == IDLE) && rdy_en_q;
        wr_ready        = (state_q == FETCH) && !rw_q && !ovf_q;
        start_operation = (state_q == ISSUE) && !busy_signal;
        rd_valid        = (state_q == HOLD);
        done            = beat_end && last_beat;
        err             = tmo_hit || ((state_q == FETCH) && ovf_q);
        rw              = rw_q;
        address_input   = addr_q;
        data_f2s        = wdat_q;
        rd_data         = rdat_q;
    end

endmodule

// File: tb/tb_sram_burst_seq.sv
// Testbench for sram_burst_seq: randomized bursts against an SRAM controller
// model, with a scoreboard of expected start pulses, read bytes and end pulses.
module tb_sram_burst_seq;

    localparam int TMO    = 4;
    localparam int K_DONE = 0;
    localparam int K_TMO  = 1;
    localparam int K_OVF  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [9:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       done, err;
    logic       start_operation, rw;
    logic [9:0] address_input;
    logic [7:0] data_f2s, data_s2f;
    logic       data_ready_signal, busy_signal;

    sram_burst_seq #(.BUSY_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .done(done), .err(err),
        .start_operation(start_operation), .rw(rw), .address_input(address_input),
        .data_f2s(data_f2s), .data_s2f(data_s2f),
        .data_ready_signal(data_ready_signal), .busy_signal(busy_signal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [9:0] addr;
        logic [7:0] data;
    } start_t;

    start_t     exp_start_q[$];
    logic [7:0] exp_rd_q[$];
    int         exp_end_q[$];
    logic [7:0] wr_src_q[$];
    logic [7:0] ref_mem [0:1023];
    logic [7:0] mem     [0:1023];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = -100;
    int last_start = -100;
    bit have_prev = 1'b0;
    int busy_mode = 0;
    bit wr_always = 1'b0;
    bit rd_always = 1'b0;
    bit rd_manual = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every DUT event pops and checks its expectation.
    start_t m_s;
    int     m_k;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (start_operation) begin
                chk("start_while_busy", 32'(busy_signal), 32'(0));
                if (have_prev) chk("start_gap_ge5", 32'((cyc - last_start) >= 5), 32'(1));
                have_prev  = 1'b1;
                last_start = cyc;
                chk("start_expected", 32'(exp_start_q.size() > 0), 32'(1));
                if (exp_start_q.size() > 0) begin
                    m_s = exp_start_q.pop_front();
                    chk("start_addr", 32'(address_input), 32'(m_s.addr));
                    chk("start_rw", 32'(rw), 32'(m_s.rw));
                    if (!m_s.rw) chk("start_wdata", 32'(data_f2s), 32'(m_s.data));
                end
            end
            if (rd_valid && rd_ready) begin
                chk("rd_expected", 32'(exp_rd_q.size() > 0), 32'(1));
                if (exp_rd_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
            if (done || err) begin
                chk("end_expected", 32'(exp_end_q.size() > 0), 32'(1));
                if (exp_end_q.size() > 0) begin
                    m_k = exp_end_q.pop_front();
                    chk("end_pulse_err_done", 32'({err, done}), (m_k == K_DONE) ? 32'(1) : 32'(2));
                    if (m_k == K_TMO) chk("tmo_latency", 32'(cyc - last_start), 32'(TMO));
                    if (m_k == K_OVF) chk("ovf_latency", 32'(cyc - acc_cyc), 32'(1));
                end
            end
        end
    end

    // Write byte source: offers queued bytes, with random gaps unless wr_always.
    initial begin
        wr_valid = 1'b0;
        wr_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (wr_src_q.size() > 0 && (wr_always || $urandom_range(0, 2) != 0)) begin
                wr_valid = 1'b1;
                wr_data  = wr_src_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
            end
        end
    end
    always @(negedge clk) if (rst_n && wr_valid && wr_ready && wr_src_q.size() > 0) void'(wr_src_q.pop_front());

    // Read sink back-pressure.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rd_manual) rd_ready = rd_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // SRAM controller model: busy rises 1..TMO cycles after start, stays 2..3 cycles.
    initial begin : ctrl
        int lat, hold;
        logic [9:0] ca;
        logic       cr;
        logic [7:0] cd;
        busy_signal = 1'b0;
        data_ready_signal = 1'b0;
        data_s2f = '0;
        forever begin
            @(negedge clk);
            if (rst_n && start_operation && busy_mode == 0) begin
                ca = address_input; cr = rw; cd = data_f2s;
                lat  = $urandom_range(1, TMO);
                hold = $urandom_range(2, 3);
                repeat (lat) @(posedge clk);
                #1 busy_signal = 1'b1;
                for (int k = 0; k < hold; k++) begin
                    if (cr && k == hold - 1) begin
                        data_ready_signal = 1'b1;
                        data_s2f = mem[ca];
                    end
                    @(posedge clk); #1;
                    data_ready_signal = 1'b0;
                end
                busy_signal = 1'b0;
                data_s2f = 8'($urandom);
                if (!cr) mem[ca] = cd;
            end
        end
    end

    // Reference model of one burst, from the command's addressing rules.
    task automatic plan_burst(input logic r, input logic [9:0] a, input logic [9:0] l,
                              input bit fixed_data, input bit tmo);
        bit ovf;
        logic [9:0] ad;
        logic [7:0] b;
`ifdef SRAM_SEQ_ADDR_WRAP_EN
        ovf = 1'b0;
`else
        ovf = (int'(a) + int'(l)) > 1023;
`endif
        if (ovf) begin
            exp_end_q.push_back(K_OVF);
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                ad = 10'((int'(a) + i) % 1024);
                b  = fixed_data ? 8'(160 + i) : 8'($urandom);
                if (!r) begin
                    wr_src_q.push_back(b);
                    exp_start_q.push_back('{1'b0, ad, b});
                    if (!tmo) ref_mem[ad] = b;
                end else begin
                    exp_start_q.push_back('{1'b1, ad, 8'h00});
                    if (!tmo) exp_rd_q.push_back(ref_mem[ad]);
                end
                if (tmo) break;
            end
            exp_end_q.push_back(tmo ? K_TMO : K_DONE);
        end
    endtask

    task automatic issue_cmd(input logic r, input logic [9:0] a, input logic [9:0] l);
        int g = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rw = r; cmd_addr = a; cmd_len = l;
        do begin @(negedge clk); g++; end while (!cmd_ready && g < 50);
        chk("cmd_accepted", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        cmd_rw = ~r; cmd_addr = 10'($urandom); cmd_len = 10'($urandom);
        @(negedge clk);
        chk("cmd_ready_low_in_burst", 32'(cmd_ready), 32'(0));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_burst();
        int g = 0;
        while (exp_end_q.size() > 0 && g < 4000) begin @(negedge clk); g++; end
        chk("burst_finished", 32'(exp_end_q.size()), 32'(0));
        chk("starts_left", 32'(exp_start_q.size()), 32'(0));
        chk("rd_left", 32'(exp_rd_q.size()), 32'(0));
        chk("wr_left", 32'(wr_src_q.size()), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic run_burst(input logic r, input logic [9:0] a, input logic [9:0] l,
                             input bit fixed_data, input bit tmo);
        plan_burst(r, a, l, fixed_data, tmo);
        issue_cmd(r, a, l);
        wait_burst();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] hb;
        int g;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_ctrl_outs", 32'({start_operation, rw, address_input, data_f2s}), 32'(0));
        chk("reset_user_outs", 32'({rd_data, rd_valid, wr_ready, done, err, cmd_ready}), 32'(0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("cmd_ready_before_edge", 32'(cmd_ready), 32'(0));
        @(posedge clk); #1;
        chk("cmd_ready_after_release", 32'(cmd_ready), 32'(1));

        // Directed write A0..A3 to 0x010 and read back.
        wr_always = 1'b1;
        run_burst(1'b0, 10'h010, 10'd3, 1'b1, 1'b0);
        wr_always = 1'b0;
        rd_always = 1'b1;
        run_burst(1'b1, 10'h010, 10'd3, 1'b0, 1'b0);
        rd_always = 1'b0;

        // Random bursts with random stalls on both byte streams.
        for (int n = 0; n < 16; n++) begin
            run_burst(1'($urandom), 10'($urandom), 10'($urandom_range(0, 12)), 1'b0, 1'b0);
        end

        // Read held in HOLD while rd_ready stays low.
        rd_manual = 1'b1;
        rd_ready  = 1'b0;
        hb = ref_mem[10'h120];
        plan_burst(1'b1, 10'h120, 10'd1, 1'b0, 1'b0);
        issue_cmd(1'b1, 10'h120, 10'd1);
        g = 0;
        while (!rd_valid && g < 100) begin @(negedge clk); g++; end
        chk("hold_rd_valid_seen", 32'(rd_valid), 32'(1));
        repeat (20) begin
            @(negedge clk);
            chk("hold_rd_valid", 32'(rd_valid), 32'(1));
            chk("hold_rd_data", 32'(rd_data), 32'(hb));
            chk("hold_no_start", 32'(start_operation), 32'(0));
        end
        @(posedge clk); #1 rd_ready = 1'b1;
        wait_burst();
        rd_manual = 1'b0;

        // Controller never raises busy.
        busy_mode = 1;
        run_burst(1'b1, 10'h050, 10'd2, 1'b0, 1'b1);
        chk("cmd_ready_after_tmo", 32'(cmd_ready), 32'(1));
        run_burst(1'b0, 10'h060, 10'd1, 1'b0, 1'b1);
        busy_mode = 0;

        // Bursts crossing the top of the address space.
        run_burst(1'b0, 10'h3FE, 10'd3, 1'b0, 1'b0);
        run_burst(1'b1, 10'h3FE, 10'd3, 1'b0, 1'b0);

        // Reset during the second beat of a 4-beat write.
        wr_always = 1'b1;
        plan_burst(1'b0, 10'h200, 10'd3, 1'b0, 1'b0);
        issue_cmd(1'b0, 10'h200, 10'd3);
        g = 0;
        while (exp_start_q.size() > 2 && g < 200) begin @(negedge clk); g++; end
        chk("rst_second_beat_seen", 32'(exp_start_q.size()), 32'(2));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midburst_rst_ctrl_outs", 32'({start_operation, rw, address_input, data_f2s}), 32'(0));
        chk("midburst_rst_user_outs", 32'({rd_data, rd_valid, wr_ready, done, err, cmd_ready}), 32'(0));
        exp_start_q.delete();
        exp_end_q.delete();
        exp_rd_q.delete();
        wr_src_q.delete();
        have_prev = 1'b0;
        wr_always = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("cmd_ready_after_midburst_rst", 32'(cmd_ready), 32'(1));
        run_burst(1'b0, 10'h300, 10'd2, 1'b0, 1'b0);
        run_burst(1'b1, 10'h300, 10'd2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
